// File: rtl/pcap_mc_fifo_to_axis_pkg.sv
// rtl/pcap_mc_fifo_to_axis_pkg.sv - shared types and packed-word field layout for the multi-channel PCAP converter
package pcap_mc_fifo_to_axis_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // Each byte lane is 9 bits wide: data byte in the low 8, strobe on top.
    localparam int LANE_BITS     = 9;
    localparam int LANE_DATA_OFS = 0;
    localparam int LANE_STRB_OFS = 8;

    function automatic int packed_width(input int data_width);
        return data_width * 9 / 8 + 1;
    endfunction

    function automatic int last_bit(input int data_width);
        return data_width * 9 / 8;
    endfunction

    function automatic int lane_lo(input int lane);
        return lane * LANE_BITS;
    endfunction

endpackage

// File: rtl/pcap_sync_fifo.sv
// rtl/pcap_sync_fifo.sv - single-clock first-word-fall-through FIFO with registered flags and dropped-write pulse
module pcap_sync_fifo #(
    parameter int WIDTH = 289,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             wr_ok;
    logic             rd_ok;

    // Full is checked before any same-cycle read, so a read never rescues a write.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign drop  = wr_en && full;
    assign dout  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + 1'b1;
        end else if (!wr_ok && rd_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (sw_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/pcap_mc_fifo_to_axis.sv
// rtl/pcap_mc_fifo_to_axis.sv - per-channel FIFOs merged by a round-robin packet arbiter onto a registered AXI4-Stream master
module pcap_mc_fifo_to_axis
    import pcap_mc_fifo_to_axis_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_CHANNELS         = 4,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                                                    axi_aclk,
    input  logic                                                    axi_aresetn,
    input  logic                                                    sw_rst,
    input  logic [NUM_CHANNELS-1:0]                                 ch_wr_en,
    input  logic [NUM_CHANNELS*packed_width(C_M_AXIS_DATA_WIDTH)-1:0] ch_din,
    output logic [NUM_CHANNELS-1:0]                                 ch_full,
    input  logic [NUM_CHANNELS-1:0]                                 ch_enable,
    output logic [NUM_CHANNELS-1:0]                                 ch_overflow,
    output logic [NUM_CHANNELS*32-1:0]                              ch_pkt_cnt,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]                          m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                        m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]                         m_axis_tuser,
    output logic                                                    m_axis_tvalid,
    input  logic                                                    m_axis_tready,
    output logic                                                    m_axis_tlast
);

    localparam int DW = C_M_AXIS_DATA_WIDTH;
    localparam int TW = C_M_AXIS_TUSER_WIDTH;
    localparam int SW = DW / 8;
    localparam int PW = packed_width(DW);
    localparam int LB = last_bit(DW);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          grant;
    logic [CW-1:0]          out_ch;
    logic [CW-1:0]          rr_sel;
    logic [CW-1:0]          rr_cand;
    logic                   rr_found;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] fifo_rd;
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] fifo_empty;
    logic [NUM_CHANNELS-1:0] fifo_drop;
    logic [PW-1:0]          fifo_dout [NUM_CHANNELS];
    logic [PW-1:0]          head_word;
    logic [DW-1:0]          head_data;
    logic [SW-1:0]          head_strb;
    logic                   head_last;
    logic [TW-1:0]          tuser_r;
    logic [31:0]            pkt_cnt [NUM_CHANNELS];
    logic                   pop_tuser;
    logic                   pop_beat;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        pcap_sync_fifo #(
            .WIDTH (PW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk    (axi_aclk),
            .rst_n  (axi_aresetn),
            .sw_rst (sw_rst),
            .wr_en  (ch_wr_en[g]),
            .din    (ch_din[g*PW +: PW]),
            .rd_en  (fifo_rd[g]),
            .dout   (fifo_dout[g]),
            .full   (fifo_full[g]),
            .empty  (fifo_empty[g]),
            .drop   (fifo_drop[g])
        );
        assign ch_pkt_cnt[g*32 +: 32] = pkt_cnt[g];
    end

    assign ch_full  = fifo_full;
    assign eligible = ch_enable & ~fifo_empty;

    // Search starts one past the last grant; grant resets to the last channel so channel 0 wins first.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = grant;
        rr_cand  = grant;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            rr_cand = (rr_cand == LAST_CH) ? '0 : rr_cand + 1'b1;
            if (!rr_found && eligible[rr_cand]) begin
                rr_found = 1'b1;
                rr_sel   = rr_cand;
            end
        end
    end

    always_comb begin
        head_word = (state == ST_IDLE) ? fifo_dout[rr_sel] : fifo_dout[grant];
        head_data = '0;
        head_strb = '0;
        for (int j = 0; j < SW; j++) begin
            head_data[8*j +: 8] = head_word[lane_lo(j) + LANE_DATA_OFS +: 8];
            head_strb[j]        = head_word[lane_lo(j) + LANE_STRB_OFS];
        end
        head_last = head_word[LB];
    end

    always_comb begin
        state_nxt = state;
        fifo_rd   = '0;
        pop_tuser = 1'b0;
        pop_beat  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rr_found) begin
                    pop_tuser       = 1'b1;
                    fifo_rd[rr_sel] = 1'b1;
                    state_nxt       = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!fifo_empty[grant] && (!m_axis_tvalid || m_axis_tready)) begin
                    pop_beat       = 1'b1;
                    fifo_rd[grant] = 1'b1;
                    if (head_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= ST_IDLE;
        end else if (sw_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            grant         <= LAST_CH;
            out_ch        <= '0;
            tuser_r       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            ch_overflow   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (sw_rst) begin
            grant         <= LAST_CH;
            out_ch        <= '0;
            tuser_r       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            ch_overflow   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else begin
            if (pop_tuser) begin
                grant   <= rr_sel;
                tuser_r <= head_data[TW-1:0];
            end
            if (pop_beat) begin
                m_axis_tdata  <= head_data;
                m_axis_tstrb  <= head_strb;
                m_axis_tuser  <= tuser_r;
                m_axis_tlast  <= head_last;
                m_axis_tvalid <= 1'b1;
                out_ch        <= grant;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            ch_overflow <= ch_overflow | fifo_drop;
            // out_ch tracks the beat in the output register, which may outlive the grant.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (out_ch == CW'(i))) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pcap_mc_fifo_to_axis.sv
// tb/tb_pcap_mc_fifo_to_axis.sv - scoreboard bench for the multi-channel PCAP FIFO-to-AXIS converter
module tb_pcap_mc_fifo_to_axis;

    localparam int DW = 256;
    localparam int TW = 128;
    localparam int N  = 4;
    localparam int DEPTH = 16;
    localparam int SW = DW / 8;
    localparam int PW = DW * 9 / 8 + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [TW-1:0] tuser;
        logic          last;
    } beat_t;

    typedef struct {
        int            ch;
        logic [TW-1:0] tuser;
        int            nbeats;
        logic [SW-1:0] last_strb;
        logic [7:0]    seed;
        logic [31:0]   exp_cnt;
    } vec_t;

    logic            clk;
    logic            axi_aresetn;
    logic            sw_rst;
    logic [N-1:0]    ch_wr_en;
    logic [N*PW-1:0] ch_din;
    logic [N-1:0]    ch_full;
    logic [N-1:0]    ch_enable;
    logic [N-1:0]    ch_overflow;
    logic [N*32-1:0] ch_pkt_cnt;
    logic [DW-1:0]   m_axis_tdata;
    logic [SW-1:0]   m_axis_tstrb;
    logic [TW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;

    pcap_mc_fifo_to_axis #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (TW),
        .NUM_CHANNELS         (N),
        .FIFO_DEPTH           (DEPTH)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (axi_aresetn),
        .sw_rst        (sw_rst),
        .ch_wr_en      (ch_wr_en),
        .ch_din        (ch_din),
        .ch_full       (ch_full),
        .ch_enable     (ch_enable),
        .ch_overflow   (ch_overflow),
        .ch_pkt_cnt    (ch_pkt_cnt),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          cyc = 0;
    int          acc_cyc[$];
    beat_t       sb[$];
    beat_t       mon_e;
    logic [31:0] exp_cnt [N];
    logic        stall_q = 1'b0;
    logic [DW-1:0] h_data;
    logic [SW-1:0] h_strb;
    logic [TW-1:0] h_tuser;
    logic          h_last;
    vec_t        vt [5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [7:0] seed, input int b);
        logic [31:0] w;
        w = {seed, 8'(b), 16'hC0DE};
        return {8{w}} ^ {DW{seed[0]}};
    endfunction

    function automatic logic [PW-1:0] pack(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        logic [PW-1:0] w;
        w = '0;
        for (int j = 0; j < SW; j++) begin
            w[9*j +: 8] = d[8*j +: 8];
            w[9*j+8]    = s[j];
        end
        w[PW-1] = l;
        return w;
    endfunction

    function automatic logic [PW-1:0] tuser_word(input logic [TW-1:0] tu);
        // strb and last deliberately set: both must be ignored on a TUSER word
        return pack({{(DW-TW){1'b0}}, tu}, '1, 1'b1);
    endfunction

    function automatic logic [PW-1:0] beat_word(input logic [7:0] seed, input int b, input int n, input logic [SW-1:0] ls);
        return pack(mkdata(seed, b), (b == n-1) ? ls : '1, b == n-1);
    endfunction

    task automatic wr(input int ch, input logic [PW-1:0] w);
        ch_din[ch*PW +: PW] = w;
        ch_wr_en[ch] = 1'b1;
        tick;
        ch_wr_en[ch] = 1'b0;
    endtask

    task automatic exp_pkt(input int ch, input logic [TW-1:0] tu, input int n, input logic [SW-1:0] ls, input logic [7:0] seed);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.data  = mkdata(seed, b);
            e.strb  = (b == n-1) ? ls : '1;
            e.tuser = tu;
            e.last  = (b == n-1);
            sb.push_back(e);
        end
        exp_cnt[ch] = exp_cnt[ch] + 1;
    endtask

    task automatic send_pkt(input int ch, input logic [TW-1:0] tu, input int n, input logic [SW-1:0] ls, input logic [7:0] seed, input bit push);
        if (push) exp_pkt(ch, tu, n, ls, seed);
        wr(ch, tuser_word(tu));
        for (int b = 0; b < n; b++) wr(ch, beat_word(seed, b, n, ls));
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && t < 300) begin
            tick;
            t++;
        end
        chk("drain_timeout", DW'(t >= 300), '0);
        tick;
        tick;
        chk("sb_empty", DW'(sb.size()), '0);
    endtask

    task automatic clear_model;
        sb.delete();
        for (int i = 0; i < N; i++) exp_cnt[i] = '0;
    endtask

    always @(negedge clk) begin
        if (!axi_aresetn) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
                chk("hold_tdata", m_axis_tdata, h_data);
                chk("hold_tstrb", DW'(m_axis_tstrb), DW'(h_strb));
                chk("hold_tuser", DW'(m_axis_tuser), DW'(h_tuser));
                chk("hold_tlast", DW'(m_axis_tlast), DW'(h_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_acc++;
                acc_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", DW'(1), '0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat_tdata", m_axis_tdata, mon_e.data);
                    chk("beat_tstrb", DW'(m_axis_tstrb), DW'(mon_e.strb));
                    chk("beat_tuser", DW'(m_axis_tuser), DW'(mon_e.tuser));
                    chk("beat_tlast", DW'(m_axis_tlast), DW'(mon_e.last));
                end
            end
            stall_q = m_axis_tvalid && !m_axis_tready;
            h_data  = m_axis_tdata;
            h_strb  = m_axis_tstrb;
            h_tuser = m_axis_tuser;
            h_last  = m_axis_tlast;
        end
    end

    initial begin
        int t;
        vt[0] = '{ch: 0, tuser: 128'h1234_5678, nbeats: 2, last_strb: 32'hFFFF_FFFF, seed: 8'h10, exp_cnt: 32'd2};
        vt[1] = '{ch: 2, tuser: 128'hBEEF,      nbeats: 1, last_strb: 32'h0000_0001, seed: 8'h21, exp_cnt: 32'd1};
        vt[2] = '{ch: 3, tuser: {4{32'hCAFE_F00D}}, nbeats: 5, last_strb: 32'h8000_0000, seed: 8'h30, exp_cnt: 32'd1};
        vt[3] = '{ch: 1, tuser: 128'h7,         nbeats: 2, last_strb: 32'h0000_0000, seed: 8'h43, exp_cnt: 32'd1};
        vt[4] = '{ch: 2, tuser: 128'h55AA,      nbeats: 3, last_strb: 32'hFFFF_FFFF, seed: 8'h50, exp_cnt: 32'd2};

        axi_aresetn   = 1'b0;
        sw_rst        = 1'b0;
        ch_wr_en      = '0;
        ch_din        = '0;
        ch_enable     = '1;
        m_axis_tready = 1'b1;
        clear_model();
        repeat (3) tick;
        axi_aresetn = 1'b1;
        tick;
        chk("rst_tvalid", DW'(m_axis_tvalid), '0);
        chk("rst_tlast", DW'(m_axis_tlast), '0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_tuser", DW'(m_axis_tuser), '0);
        chk("rst_ch_full", DW'(ch_full), '0);
        chk("rst_overflow", DW'(ch_overflow), '0);
        chk("rst_pkt_cnt", DW'(ch_pkt_cnt), '0);

        // start-of-packet latency: TUSER at edge 0, beat 0 at edge 1, tvalid from cycle 3
        exp_pkt(0, 128'hA5, 3, 32'h0000_FFFF, 8'h01);
        wr(0, tuser_word(128'hA5));
        wr(0, beat_word(8'h01, 0, 3, 32'h0000_FFFF));
        chk("lat_tvalid_c2", DW'(m_axis_tvalid), '0);
        wr(0, beat_word(8'h01, 1, 3, 32'h0000_FFFF));
        chk("lat_tvalid_c3", DW'(m_axis_tvalid), DW'(1));
        wr(0, beat_word(8'h01, 2, 3, 32'h0000_FFFF));
        drain();
        chk("lat_pkt_cnt0", DW'(ch_pkt_cnt[31:0]), DW'(1));

        for (int v = 0; v < 5; v++) begin
            send_pkt(vt[v].ch, vt[v].tuser, vt[v].nbeats, vt[v].last_strb, vt[v].seed, 1'b1);
            drain();
            chk("vec_pkt_cnt", DW'(ch_pkt_cnt[vt[v].ch*32 +: 32]), DW'(vt[v].exp_cnt));
        end

        // backpressure: tready toggles every cycle during a 4-beat packet
        n_acc = 0;
        fork
            begin
                repeat (24) begin
                    tick;
                    m_axis_tready = ~m_axis_tready;
                end
                m_axis_tready = 1'b1;
            end
            begin
                send_pkt(2, 128'hB00B, 4, 32'h0F0F_0F0F, 8'h66, 1'b1);
                drain();
            end
        join
        drain();
        chk("bp_beats", DW'(n_acc), DW'(4));
        chk("bp_pkt_cnt2", DW'(ch_pkt_cnt[2*32 +: 32]), DW'(exp_cnt[2]));

        // overflow: ch1 disabled so nothing drains it
        ch_enable = 4'b1101;
        for (int i = 0; i < 16; i++) begin
            wr(1, beat_word(8'h70, i, 20, '1));
            if (i == 14) chk("ovf_full_at15", DW'(ch_full[1]), '0);
        end
        chk("ovf_full_at16", DW'(ch_full[1]), DW'(1));
        chk("ovf_flag_at16", DW'(ch_overflow[1]), '0);
        wr(1, beat_word(8'h70, 16, 20, '1));
        chk("ovf_flag_at17", DW'(ch_overflow), DW'(4'b0010));
        sw_rst = 1'b1;
        tick;
        sw_rst = 1'b0;
        clear_model();
        chk("swrst_full", DW'(ch_full), '0);
        chk("swrst_overflow", DW'(ch_overflow), '0);
        chk("swrst_pkt_cnt", DW'(ch_pkt_cnt), '0);

        // round robin after sw_rst: order 0,1,3,0,1,3 with one bubble each
        ch_enable = '0;
        for (int r = 0; r < 2; r++) begin
            send_pkt(0, 128'h100 + 128'(r), 1, '1, 8'h80 + 8'(r), 1'b0);
            send_pkt(1, 128'h110 + 128'(r), 1, '1, 8'h90 + 8'(r), 1'b0);
            send_pkt(3, 128'h130 + 128'(r), 1, '1, 8'hB0 + 8'(r), 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            exp_pkt(0, 128'h100 + 128'(r), 1, '1, 8'h80 + 8'(r));
            exp_pkt(1, 128'h110 + 128'(r), 1, '1, 8'h90 + 8'(r));
            exp_pkt(3, 128'h130 + 128'(r), 1, '1, 8'hB0 + 8'(r));
        end
        acc_cyc.delete();
        ch_enable = '1;
        drain();
        chk("rr_beats", DW'(acc_cyc.size()), DW'(6));
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("rr_gap", DW'(acc_cyc[i] - acc_cyc[i-1]), DW'(2));
        end
        chk("rr_pkt_cnt", DW'(ch_pkt_cnt), {160'd0, 32'd2, 32'd0, 32'd2, 32'd2});

        // async reset after beat 2 of a 4-beat packet
        ch_enable = '0;
        send_pkt(0, 128'hDEAD, 4, '1, 8'hD0, 1'b1);
        n_acc = 0;
        ch_enable = '1;
        t = 0;
        while (n_acc < 2 && t < 100) begin
            tick;
            t++;
        end
        chk("rstmid_timeout", DW'(t >= 100), '0);
        axi_aresetn = 1'b0;
        #1;
        chk("rstmid_tvalid", DW'(m_axis_tvalid), '0);
        chk("rstmid_pkt_cnt", DW'(ch_pkt_cnt), '0);
        chk("rstmid_full", DW'(ch_full), '0);
        clear_model();
        tick;
        tick;
        axi_aresetn = 1'b1;
        tick;
        ch_enable = '0;
        send_pkt(3, 128'hF3, 2, 32'h0000_00FF, 8'hE3, 1'b0);
        send_pkt(0, 128'hF0, 2, 32'h0000_0003, 8'hE0, 1'b0);
        exp_pkt(0, 128'hF0, 2, 32'h0000_0003, 8'hE0);
        exp_pkt(3, 128'hF3, 2, 32'h0000_00FF, 8'hE3);
        ch_enable = '1;
        drain();
        chk("post_pkt_cnt", DW'(ch_pkt_cnt), {160'd0, 32'd1, 32'd0, 32'd0, 32'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
